// File: rtl/bus_dest_writer_pkg.sv
// Shared destination codes and bus width for the operand select mux and its write-side writer.
// One-hot destination masks let the writer test holds and drive loads from a single vector.
package bus_dest_writer_pkg;

  localparam int WIDTH = 12;

  typedef enum logic [1:0] {
    DEST_A   = 2'd0,
    DEST_B   = 2'd1,
    DEST_C   = 2'd2,
    DEST_ALL = 2'd3
  } dest_e;

  // Bit 0 = A, bit 1 = B, bit 2 = C.
  function automatic logic [2:0] dest_mask(input dest_e dest);
    logic [2:0] mask;
    mask = 3'b000;
    case (dest)
      DEST_A:   mask = 3'b001;
      DEST_B:   mask = 3'b010;
      DEST_C:   mask = 3'b100;
      DEST_ALL: mask = 3'b111;
      default:  mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bus_dest_writer_sync_fifo.sv
// Single-clock FIFO, DEPTH entries; dout shows the head combinationally, zero read latency.
// Pushes while full and pops while empty are ignored; callers are expected to gate them.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap for free since DEPTH is a power of two.
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_dest_writer.sv
// Buffers tagged bus words and commits them in order into registers A/B/C (or all three).
// Empty-FIFO word commits one edge after its push; a held destination stalls the head and all behind it.
module bus_dest_writer
  import bus_dest_writer_pkg::*;
#(
  parameter int WIDTH = bus_dest_writer_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_dest,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold_a,
  input  logic                   hold_b,
  input  logic                   hold_c,
  input  logic                   ack_a,
  input  logic                   ack_b,
  input  logic                   ack_c,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [WIDTH-1:0]       out_c,
  output logic                   fresh_a,
  output logic                   fresh_b,
  output logic                   fresh_c,
  output logic [$clog2(DEPTH):0] count
);

  logic [WIDTH+1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             commit;
  dest_e            head_dest;
  logic [WIDTH-1:0] head_data;
  logic [2:0]       head_mask;
  logic [2:0]       hold_vec;
  logic [2:0]       ack_vec;
  logic [2:0]       load;

  logic [WIDTH-1:0] out_q [3];
  logic [WIDTH-1:0] out_d [3];
  logic [2:0]       fresh_q, fresh_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({in_dest, in_data}),
    .pop   (commit),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_dest = dest_e'(fifo_dout[WIDTH+1:WIDTH]);
  assign head_data = fifo_dout[WIDTH-1:0];
  assign head_mask = dest_mask(head_dest);
  assign hold_vec  = {hold_c, hold_b, hold_a};
  assign ack_vec   = {ack_c, ack_b, ack_a};

  // Broadcast needs every hold low; single targets only their own.
  assign commit = !fifo_empty && ((head_mask & hold_vec) == 3'b000);
  assign load   = commit ? head_mask : 3'b000;

  always_comb begin
    out_d   = out_q;
    fresh_d = fresh_q;
    for (int i = 0; i < 3; i++) begin
      // A commit outranks a same-edge ack so the new value is never reported as consumed.
      if (load[i]) begin
        out_d[i]   = head_data;
        fresh_d[i] = 1'b1;
      end else if (ack_vec[i]) begin
        fresh_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        out_q[i] <= '0;
      end
      fresh_q <= 3'b000;
    end else begin
      out_q   <= out_d;
      fresh_q <= fresh_d;
    end
  end

  assign out_a   = out_q[0];
  assign out_b   = out_q[1];
  assign out_c   = out_q[2];
  assign fresh_a = fresh_q[0];
  assign fresh_b = fresh_q[1];
  assign fresh_c = fresh_q[2];

endmodule

// File: doc/bus_dest_writer.md
Name: bus_dest_writer

Overview:
- Write-side counterpart of the 3-source, 12-bit operand select mux in the Lab 5 datapath.
- The mux picks one of A/B/C onto a shared bus. This block takes words from the shared bus, each tagged with a destination. It buffers them in a small FIFO and commits each into register A, B or C, or all three (broadcast).
- Each destination register has a hold input from its consumer and a fresh/ack flag pair.
- The outputs drive the A/B/C inputs of the select mux.

Parameters:
- WIDTH, 12, data width of the bus and of each destination register.
- DEPTH, 2, number of FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  bus word.
- in_dest  input  2  destination: 0=A, 1=B, 2=C, 3=broadcast.
- in_valid  input  1  word offered this cycle.
- in_ready  output  1  FIFO can accept a word; combinational, equals (count != DEPTH).
- hold_a, hold_b, hold_c  input  1 each  destination busy; blocks commit to that register.
- ack_a, ack_b, ack_c  input  1 each  consumer has taken the value; clears the matching fresh flag.
- out_a, out_b, out_c  output  WIDTH each  destination registers.
- fresh_a, fresh_b, fresh_c  output  1 each  register written since the last ack.
- count  output  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, asynchronous: out_a/b/c=0, fresh_a/b/c=0, count=0, read/write pointers=0, so in_ready=1.
  - Reset asserted mid-operation discards all FIFO contents at once.
  - No commit happens on the edge at which reset is released.
- Push: on a clk edge where in_valid && in_ready, {in_dest, in_data} is written at wr_ptr and wr_ptr advances.
  - Pointers wrap modulo DEPTH.
  - When in_ready=0, in_valid is ignored and the word is not captured. The sender must hold the word until it sees in_ready=1.
- Commit (pop): on a clk edge where count != 0 and the head's destination is unblocked, the head entry is committed.
  - Unblocked for dest 0/1/2 means the matching hold is low.
  - Unblocked for dest 3 means hold_a, hold_b and hold_c are all low.
  - On commit, the target register(s) load the head data, their fresh flag(s) set to 1, and rd_ptr advances.
  - At most one commit per cycle. Commits are strictly in order: a blocked head stalls every entry behind it (no bypass).
- count: +1 on push only, -1 on commit only, unchanged on push and commit in the same cycle.
  - in_ready is computed from the current count, not from a same-cycle pop. A full FIFO therefore refuses a push even while committing.
- Latency:
  - FIFO empty, destination unblocked: a word pushed at edge N is committed at edge N+1. out_x and fresh_x are visible after edge N+1.
  - A word is never committed on the edge at which it is pushed.
- Fresh flags:
  - ack_x with no commit to x clears fresh_x at the next edge.
  - A commit to x and ack_x on the same edge: the commit wins and fresh_x stays 1.
  - ack_x while fresh_x=0 has no effect.
- Outputs are registered. out_x changes only on a commit to x.
- Data is stored and committed bit-exact at WIDTH; no arithmetic is performed.

Decomposition:
- Shared package/include: destination codes DEST_A=2'd0, DEST_B=2'd1, DEST_C=2'd2, DEST_ALL=2'd3, and WIDTH=12. The select mux uses the same values.
- One natural sub-module, sync_fifo: parameterised WIDTH+2 by DEPTH.
  - Ports: clk, reset, push, din, pop, dout, count, full, empty.
- The top level holds the commit/unblock logic, the three destination registers and the fresh flags.

Test Plan:
- Reset, then push (254, dest 0), (2142, dest 1), (1565, dest 2) on consecutive edges with holds low:
  - out_a=254 one edge after its push, then out_b=2142, then out_c=1565.
  - fresh_a/b/c all 1; count never exceeds 1.
- hold_b=1, then push (100, B) and (200, A):
  - count reaches 2 and in_ready=0.
  - A third push (300, C) is not accepted.
  - out_a stays 0 (in-order stall).
  - Release hold_b: out_b=100 at the next edge, out_a=200 the edge after.
- Push (0xABC, dest 3) with hold_c=1:
  - No register changes.
  - Drop hold_c: out_a=out_b=out_c=0xABC on the same edge and all fresh flags set.
- With fresh_a=1, pulse ack_a on the same edge as a commit of (55, A): fresh_a remains 1 and out_a=55. Pulse ack_a alone next cycle: fresh_a=0.
- Fill the FIFO to 2 with hold_a=1, then assert reset asynchronously mid-cycle:
  - Outputs go to 0, count=0 and in_ready=1 immediately without a clock edge.
  - After release, no stale word is committed.
- DEPTH=4 run of 10 back-to-back pushes (values 1..10, alternating A/B) with hold_a toggled every 3 cycles:
  - Commit order exactly matches push order.
  - Pointers wrap cleanly and count stays within 0..4.
